sseg_scan: RTL and testbench
============================

# sseg_scan

Time-multiplexed scanner for a 4-digit common-anode seven-segment display. Holds a 16-bit hex value, cycles one digit at a time at a prescaled rate, and drives the active-low anode enables plus the 4-bit nibble for the current digit. Sits directly upstream of the `ssegdec` hex-to-segment decoder, which consumes `binary` and produces the cathode pattern. New values are double-buffered and take effect only at a frame boundary, so a displayed frame never mixes old and new digits.

## Interface
- `PRESCALE`, default 100000: clock cycles per digit slot (100 MHz gives 1 kHz per digit); legal range ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  16  hex value; digit 0 = `value[3:0]` (rightmost), digit 3 = `value[15:12]`.
- `load`  in  1  one-cycle strobe that captures `value` into the pending register.
- `blank_lz`  in  1  level; 1 blanks leading zero digits.
- `busy`  out  1  a loaded value is pending and not yet displayed.
- `an`  out  4  anode enables, active low; at most one bit low.
- `binary`  out  4  nibble for the enabled digit, feeds `ssegdec`.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` = (pcnt == PRESCALE-1). With PRESCALE = 1, `tick` is high every cycle.
- Digit index `dig` (2 bits) increments on `tick` and wraps 3→0. Frame boundary = `tick` && `dig` == 3.
- Registers: `disp[15:0]` (shown), `pend[15:0]`, `pend_v`.
  - `load`: `pend` ← `value`, `pend_v` ← 1. Repeated loads overwrite, so the last one wins.
  - At the frame boundary with `pend_v` = 1: `disp` ← `pend`, `pend_v` ← 0, on the same edge that `dig` wraps to 0.
  - `load` coincident with a transferring boundary: `disp` takes the old `pend`, `pend` takes the new `value`, and `pend_v` stays 1.
  - `busy` = `pend_v`.
- Leading-zero blanking (when `blank_lz` = 1): digit i (i = 3, 2, 1) is blanked if `disp` nibbles 3 down to i are all zero. Digit 0 is never blanked. A blanked digit drives `an` = 4'b1111 for its slot, and `binary` still carries its nibble.
- Outputs are registered. Each cycle:
  - `an` ← blanked ? 4'b1111 : ~(4'b0001 << `dig`).
  - `binary` ← `disp[4*dig +: 4]`.
- `blank_lz` is sampled combinationally into the output register each cycle. A change is visible one cycle later.

## Timing
- Reset values: `pcnt` = 0, `dig` = 0, `disp` = 0, `pend` = 0, `pend_v` = 0, `an` = 4'b1111, `binary` = 0, `busy` = 0.
- First cycle after `reset` deasserts: `an` = 4'b1110, `binary` = 0.
- `an` and `binary` lag `dig` and `disp` by exactly one cycle.
- Each digit slot lasts exactly PRESCALE cycles. A full frame lasts 4·PRESCALE cycles.
- Load-to-display latency: from the `load` edge to digit 0 of the new value appearing on `binary`, at most 4·PRESCALE + 1 cycles and at least 2 cycles.
- `busy` rises the cycle after `load` and falls the cycle after the transferring boundary.
- `reset` mid-frame clears all state, including any pending value. The pending value is discarded, not displayed.

## Structure
- Package `sseg_pkg`:
  - `NUM_DIGITS` = 4
  - `typedef logic [1:0] digit_idx_t`
  - `AN_OFF` = 4'b1111
  - `NIBBLE_W` = 4
- Sub-module `tick_gen`: parameterised prescaler, ports `clk`, `reset`, `tick`, counter width $clog2(PRESCALE) (minimum 1).
- Scanner, buffering and blanking live in `sseg_scan`. The `ssegdec` decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios use PRESCALE = 4.
- Reset, then release, no load -> `an` = 1111 during reset, then steps 1110, 1101, 1011, 0111, 1110 every 4 cycles. `binary` = 0 throughout and `busy` = 0.
- `load` with `value` = 16'h1234 while on digit 1 -> `busy` = 1. The rest of the frame still shows 0. After the wrap, digits 0..3 show 4, 3, 2, 1, and `busy` falls the cycle after the boundary.
- Loads of 16'hAAAA then 16'h5555 in the same frame -> the next frame shows 5 on every digit. A shows on no digit.
- `blank_lz` = 1, `value` = 16'h0050 -> digit 3 and digit 2 slots show `an` = 1111, digit 1 shows `binary` = 5, digit 0 shows `binary` = 0. With `value` = 16'h0000, only digit 0 is enabled.
- `load` of 16'hBEEF asserted on the boundary cycle while 16'h1111 is pending -> the next frame shows 1111, `busy` stays 1, and the following frame shows BEEF.
- `reset` pulsed mid-frame with `busy` = 1 -> state clears and `an` = 1111 for the reset cycle. After release, `an` restarts at 1110 with `binary` = 0 and the pending value is never displayed.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scanner.
package sseg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-hot anode enable for a digit slot.
    function automatic logic [3:0] an_select(input digit_idx_t d);
        return ~(4'b0001 << d);
    endfunction
endpackage

// File: rtl/sseg_scan_tick_gen.sv
// Free-running prescaler: tick is high on the last cycle of each PRESCALE-cycle slot.
module tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (pcnt_q == LAST) pcnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) pcnt_q <= '0;
        else       pcnt_q <= pcnt_d;
    end

    assign tick = (pcnt_q == LAST);
endmodule

// File: rtl/sseg_scan.sv
// 4-digit multiplexed display scanner with frame-aligned double buffering
// and optional leading-zero blanking.
module sseg_scan
    import sseg_pkg::*;
#(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic        busy,
    output logic [3:0]  an,
    output logic [3:0]  binary
);
    logic             tick;
    digit_idx_t       dig_q;
    logic [15:0]      disp_q, pend_q;
    logic             pend_v_q;
    logic [3:0]       an_q, an_d;
    logic [NIBBLE_W-1:0] binary_q, binary_d;
    logic [3:0]       lz;
    logic             frame_end, xfer;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign frame_end = tick && (dig_q == digit_idx_t'(NUM_DIGITS - 1));
    assign xfer      = frame_end && pend_v_q;

    // lz[i]: every nibble from the top down to digit i is zero.
    always_comb begin
        lz    = '0;
        lz[3] = (disp_q[15:12] == '0);
        lz[2] = lz[3] && (disp_q[11:8] == '0);
        lz[1] = lz[2] && (disp_q[7:4] == '0);
        lz[0] = 1'b0;
        an_d     = (blank_lz && lz[dig_q]) ? AN_OFF : an_select(dig_q);
        binary_d = disp_q[int'(dig_q) * NIBBLE_W +: NIBBLE_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig_q    <= '0;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            an_q     <= AN_OFF;
            binary_q <= '0;
        end else begin
            if (tick) dig_q <= dig_q + 1'b1;
            if (xfer) disp_q <= pend_q;
            // A load on the transfer edge queues behind the value being shown.
            if (load) begin
                pend_q   <= value;
                pend_v_q <= 1'b1;
            end else if (xfer) begin
                pend_v_q <= 1'b0;
            end
            an_q     <= an_d;
            binary_q <= binary_d;
        end
    end

    assign busy   = pend_v_q;
    assign an     = an_q;
    assign binary = binary_q;
endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan with PRESCALE = 4 (16-cycle frames).
module tb_sseg_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [3:0]  binary;

    int checks = 0;
    int errors = 0;
    int n = 0;

    sseg_scan #(.PRESCALE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .busy     (busy),
        .an       (an),
        .binary   (binary)
    );

    always #5 clk = ~clk;

    function automatic bit exp_blank(input logic [15:0] v, input int d);
        if (d == 0) return 1'b0;
        for (int i = 3; i >= d; i--)
            if (v[4*i +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Step cnt cycles, checking the outputs against the value expected on display.
    task automatic run_steps(input int cnt, input logic [15:0] shown, input bit blz);
        int d;
        logic [3:0] e_an, e_bin;
        for (int k = 0; k < cnt; k++) begin
            step();
            d = ((n - 1) / 4) % 4;
            e_bin = shown[4*d +: 4];
            e_an = (blz && exp_blank(shown, d)) ? 4'b1111 : ~(4'b0001 << d);
            checks++;
            if (an !== e_an) begin
                errors++;
                $display("FAIL an step %0d: got %b want %b", n, an, e_an);
            end
            checks++;
            if (binary !== e_bin) begin
                errors++;
                $display("FAIL binary step %0d: got %h want %h", n, binary, e_bin);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (an !== 4'b1111 || binary !== 4'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got an=%b bin=%h busy=%b want 1111 0 0", an, binary, busy);
            end
        end
        reset = 1'b0;
        n = 0;
        run_steps(16, 16'h0000, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_load();
        run_steps(4, 16'h0000, 1'b0);
        value = 16'h1234;
        load = 1'b1;
        run_steps(1, 16'h0000, 1'b0);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy_rise: got %b want 1", busy);
        end
        run_steps(10, 16'h0000, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy_hold: got %b want 1", busy);
        end
        run_steps(1, 16'h0000, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load_busy_fall: got %b want 0", busy);
        end
        run_steps(16, 16'h1234, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_steps(2, 16'h1234, 1'b0);
        value = 16'hAAAA;
        load = 1'b1;
        run_steps(1, 16'h1234, 1'b0);
        load = 1'b0;
        run_steps(3, 16'h1234, 1'b0);
        value = 16'h5555;
        load = 1'b1;
        run_steps(1, 16'h1234, 1'b0);
        load = 1'b0;
        run_steps(9, 16'h1234, 1'b0);
        run_steps(16, 16'h5555, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_blanking();
        blank_lz = 1'b1;
        value = 16'h0050;
        load = 1'b1;
        run_steps(1, 16'h5555, 1'b1);
        load = 1'b0;
        run_steps(15, 16'h5555, 1'b1);
        run_steps(16, 16'h0050, 1'b1);
        value = 16'h0000;
        load = 1'b1;
        run_steps(1, 16'h0050, 1'b1);
        load = 1'b0;
        run_steps(15, 16'h0050, 1'b1);
        run_steps(16, 16'h0000, 1'b1);
        blank_lz = 1'b0;
        run_steps(16, 16'h0000, 1'b0);
    endtask

    task automatic test_boundary_load();
        value = 16'h1111;
        load = 1'b1;
        run_steps(1, 16'h0000, 1'b0);
        load = 1'b0;
        run_steps(14, 16'h0000, 1'b0);
        value = 16'hBEEF;
        load = 1'b1;
        run_steps(1, 16'h0000, 1'b0);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL boundary_busy_stays: got %b want 1", busy);
        end
        run_steps(16, 16'h1111, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL boundary_busy_fall: got %b want 0", busy);
        end
        run_steps(16, 16'hBEEF, 1'b0);
    endtask

    task automatic test_reset_mid();
        value = 16'hCAFE;
        load = 1'b1;
        run_steps(1, 16'hBEEF, 1'b0);
        load = 1'b0;
        run_steps(5, 16'hBEEF, 1'b0);
        reset = 1'b1;
        step();
        checks++;
        if (an !== 4'b1111 || binary !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got an=%b bin=%h busy=%b want 1111 0 0", an, binary, busy);
        end
        reset = 1'b0;
        n = 0;
        run_steps(32, 16'h0000, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: got %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_blanking();
        test_boundary_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
